// File: rtl/regfile_pkg.sv
// Shared constants, default types and the address-width helper for the
// register file with busy scoreboard.
package regfile_pkg;

    localparam int RF_WIDTH = 64;
    localparam int RF_DEPTH = 32;
    localparam int RF_ZERO  = 31;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [63:0] rf_data_t;

    // Index width for a depth, never below one bit so a 2-entry file still has an address.
    function automatic int addrWidth(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_reg_cell.sv
// Single storage element with enable-hold and asynchronous active-high clear;
// used for both data registers and busy flags.
module reg_cell #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass, optional hard-wired
// zero register and a per-entry busy scoreboard for hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = RF_ZERO,
    parameter  int ZERO_EN  = 1,
    localparam int AW       = addrWidth(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 any_busy
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [WIDTH-1:0] regQ [DEPTH];
    logic [DEPTH-1:0] busyQ;
    logic [DEPTH-1:0] wrHit;
    logic [DEPTH-1:0] issHit;

    logic [AW-1:0]     rdIdx [NUM_RD];
    logic [NUM_RD-1:0] rdZero;
    logic [NUM_RD-1:0] rdBypass;

    // The zero entry never sees an enable, so it keeps its reset value of 0.
    always_comb begin
        wrHit  = '0;
        issHit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wrHit[i]  = wr_en  && (wr_addr  == AW'(i)) && !((ZERO_EN != 0) && (i == ZERO_REG));
            issHit[i] = iss_en && (iss_addr == AW'(i)) && !((ZERO_EN != 0) && (i == ZERO_REG));
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : gEntry
            reg_cell #(.WIDTH(WIDTH)) uData (
                .clk   (clk),
                .reset (reset),
                .en    (wrHit[g]),
                .d     (wr_data),
                .q     (regQ[g])
            );

            // A new issue outranks a retiring writeback to the same entry.
            reg_cell #(.WIDTH(1)) uBusy (
                .clk   (clk),
                .reset (reset),
                .en    (wrHit[g] | issHit[g]),
                .d     (issHit[g]),
                .q     (busyQ[g])
            );
        end
    endgenerate

    always_comb begin
        rdZero   = '0;
        rdBypass = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdIdx[k]    = rd_addr[k*AW +: AW];
            rdZero[k]   = (ZERO_EN != 0) && (rdIdx[k] == ZERO_IDX);
            rdBypass[k] = wr_en && (wr_addr == rdIdx[k]) && !rdZero[k];
        end
    end

    // Reset gates the bypass path too, so outputs read zero while reset is held.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!reset && !rdZero[k]) begin
                if (rdBypass[k]) begin
                    rd_data[k*WIDTH +: WIDTH] = wr_data;
                end else begin
                    rd_data[k*WIDTH +: WIDTH] = regQ[rdIdx[k]];
                end
                rd_busy[k] = busyQ[rdIdx[k]] && !rdBypass[k];
            end
        end
    end

    assign any_busy = |busyQ;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard at default parameters.
module tb_regfile_scoreboard;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_addr;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic         any_busy;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(
        .WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .ZERO_EN(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'(i * 3 + 1)};
    endfunction

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
        #1;
        total++; if (rd_data !== 128'h0) begin bad++; $display("FAIL reset_init_rd got=%h exp=0", rd_data); end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL reset_init_any got=%b exp=0", any_busy); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd5;
        @(negedge clk);
        idle(); rd_addr = {5'd5, 5'd5};
        #1;
        total++; if (rd_data[63:0] !== 64'hDEAD_BEEF) begin bad++; $display("FAIL reset_pre_rd got=%h exp=deadbeef", rd_data[63:0]); end
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL reset_pre_busy got=%b exp=11", rd_busy); end
        #1;
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
        #1;
        total++; if (rd_data !== 128'h0) begin bad++; $display("FAIL reset_mid_rd got=%h exp=0", rd_data); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_mid_busy got=%b exp=00", rd_busy); end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL reset_mid_any got=%b exp=0", any_busy); end
        @(negedge clk); idle(); reset = 1'b0;
        #1;
        total++; if (rd_data[63:0] !== 64'h0) begin bad++; $display("FAIL reset_post_rd got=%h exp=0", rd_data[63:0]); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        idle(); rd_addr = {5'd3, 5'd3};
        #1;
        total++; if (rd_data[63:0] !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL wr_rd_p0 got=%h exp=0123456789abcdef", rd_data[63:0]); end
        total++; if (rd_data[127:64] !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL wr_rd_p1 got=%h exp=0123456789abcdef", rd_data[127:64]); end
        rd_addr = {5'd4, 5'd3};
        #1;
        total++; if (rd_data[127:64] !== 64'h0) begin bad++; $display("FAIL wr_rd_unwritten got=%h exp=0", rd_data[127:64]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h22; rd_addr = {5'd3, 5'd7};
        #1;
        total++; if (rd_data[63:0] !== 64'h22) begin bad++; $display("FAIL bypass_same got=%h exp=22", rd_data[63:0]); end
        total++; if (rd_data[127:64] !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL bypass_other got=%h exp=0123456789abcdef", rd_data[127:64]); end
        @(negedge clk);
        idle();
        #1;
        total++; if (rd_data[63:0] !== 64'h22) begin bad++; $display("FAIL bypass_after got=%h exp=22", rd_data[63:0]); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd31; rd_addr = {5'd31, 5'd31};
        #1;
        total++; if (rd_data !== 128'h0) begin bad++; $display("FAIL zero_nobypass got=%h exp=0", rd_data); end
        @(negedge clk);
        idle();
        #1;
        total++; if (rd_data !== 128'h0) begin bad++; $display("FAIL zero_read got=%h exp=0", rd_data); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL zero_busy got=%b exp=00", rd_busy); end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL zero_any got=%b exp=0", any_busy); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd10; rd_addr = {5'd10, 5'd10};
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL sb_issue_same got=%b exp=00", rd_busy); end
        @(negedge clk);
        idle();
        #1;
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL sb_issue_next got=%b exp=11", rd_busy); end
        total++; if (any_busy !== 1'b1) begin bad++; $display("FAIL sb_issue_any got=%b exp=1", any_busy); end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'hAB;
        iss_en = 1'b1; iss_addr = 5'd10;
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL sb_both_hidden got=%b exp=00", rd_busy); end
        @(negedge clk);
        idle();
        #1;
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL sb_both_after got=%b exp=11", rd_busy); end
        total++; if (rd_data[63:0] !== 64'hAB) begin bad++; $display("FAIL sb_both_data got=%h exp=ab", rd_data[63:0]); end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'hCD;
        @(negedge clk);
        idle();
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL sb_clear_busy got=%b exp=00", rd_busy); end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL sb_clear_any got=%b exp=0", any_busy); end
    endtask

    task automatic test_enable_hold();
        logic [63:0] e0;
        logic [63:0] e1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = pat(i);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            wr_en = 1'b0; wr_addr = 5'(c * 5);
            wr_data = c[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle(); rd_addr = {5'(31 - i), 5'(i)};
            e0 = (i == 31) ? 64'h0 : pat(i);
            e1 = (i == 0) ? 64'h0 : pat(31 - i);
            #1;
            total++; if (rd_data[63:0] !== e0) begin bad++; $display("FAIL hold_p0 idx=%0d got=%h exp=%h", i, rd_data[63:0], e0); end
            total++; if (rd_data[127:64] !== e1) begin bad++; $display("FAIL hold_p1 idx=%0d got=%h exp=%h", 31 - i, rd_data[127:64], e1); end
        end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL hold_any got=%b exp=0", any_busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_enable_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port register file for the ARM datapath: DEPTH entries of WIDTH bits, one write port, NUM_RD combinational read ports.
- Write-to-read bypass within the same cycle; a hard-wired zero register (XZR).
- Per-entry busy scoreboard for pipeline hazard detection. Issue marks a destination busy; writeback clears it.
- Sits between decode (read and issue) and writeback in the pipelined CPU.

Parameters:
- WIDTH, 64, data bits per register
- DEPTH, 32, number of registers; must be a power of two and at least 2
- NUM_RD, 2, number of read ports, 1 to 4
- ZERO_REG, 31, index of the hard-wired zero register
- ZERO_EN, 1, 1 enables zero-register behaviour; 0 makes ZERO_REG an ordinary register

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  write enable (writeback)
- wr_addr  in  log2(DEPTH)  write index
- wr_data  in  WIDTH  write data
- iss_en  in  1  issue: mark iss_addr busy
- iss_addr  in  log2(DEPTH)  destination being issued
- rd_addr  in  NUM_RD*log2(DEPTH)  packed read indices; port k uses slice k
- rd_data  out  NUM_RD*WIDTH  packed read data
- rd_busy  out  NUM_RD  per-port busy flag of the addressed entry
- any_busy  out  1  OR of all busy bits

Behaviour:
- Reset (asserted): all DEPTH registers = 0, all busy bits = 0. As a consequence, rd_data = 0, rd_busy = 0 and any_busy = 0 while reset is high, independent of inputs. Reset takes effect immediately, with no clock needed.
- Deassertion of reset is synchronised by the system; the block itself takes no action on deassertion.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data. With wr_en=0, every register holds its value (enable-hold, no glitch on unaddressed entries).
- Read: combinational, zero-cycle latency.
  - rd_data[k] = reg[rd_addr[k]] in the normal case.
  - Bypass: if wr_en=1 and wr_addr == rd_addr[k], then rd_data[k] = wr_data in the same cycle.
- Zero register (ZERO_EN=1):
  - Writes to ZERO_REG are discarded.
  - Reads of ZERO_REG return 0. Bypass never applies to ZERO_REG.
  - iss_en to ZERO_REG does not set busy; its busy bit is constantly 0.
- Scoreboard, at the rising edge, per entry i:
  - set = iss_en and iss_addr == i
  - clr = wr_en and wr_addr == i
  - set and clr both true: busy[i] <= 1. The new producer wins over the retiring one.
  - clr only: busy[i] <= 0
  - set only: busy[i] <= 1
  - neither: hold
- rd_busy[k]:
  - Equals busy[rd_addr[k]] AND NOT (wr_en and wr_addr == rd_addr[k]).
  - A same-cycle writeback therefore hides the busy flag, consistent with the bypass.
  - The same-cycle iss_en does not affect rd_busy; it is visible from the next cycle.
- any_busy: registered busy vector OR-reduced (combinational from state).
- Multiple read ports addressing the same entry each return identical data and busy values.
- Address width is log2(DEPTH), so no out-of-range addresses exist.

Decomposition:
- Package regfile_pkg:
  - Default constants: RF_WIDTH=64, RF_DEPTH=32, RF_ZERO=31.
  - Typedef rf_addr_t (logic [4:0]) and rf_data_t (logic [63:0]) for the defaults.
  - Function clog2-safe address-width helper.
- Sub-module reg_cell:
  - One WIDTH-bit register with enable-hold and asynchronous active-high reset.
  - The top level generates DEPTH instances, plus a 1-bit instance per busy flag.
- Read muxing, bypass compare and the write decoder stay in the top level.

Test Plan:
- Reset mid-operation: write reg5 = 64'hDEAD_BEEF, set busy on reg5, assert reset between clock edges. Required: rd_data for reg5 = 0, rd_busy = 0 and any_busy = 0 immediately, before the next edge.
- Write then read: write reg3 = 64'h0123_4567_89AB_CDEF. Required: next cycle rd_addr[0]=3 and rd_addr[1]=3 both return that value. An unwritten reg4 returns 0.
- Bypass: reg7 = 64'h11 stored; in the same cycle present wr_en=1, wr_addr=7, wr_data=64'h22 and rd_addr[0]=7. Required: rd_data[0] = 64'h22 before the edge and 64'h22 after it.
- Zero register: write 31 = 64'hFFFF_FFFF_FFFF_FFFF and issue to 31. Required: reads of 31 return 0, rd_busy = 0, any_busy = 0.
- Scoreboard:
  - Issue reg10. Required: rd_busy = 1 next cycle.
  - Writeback reg10 and re-issue reg10 in the same cycle. Required: busy stays 1 after the edge; rd_busy = 0 in that cycle due to the writeback.
  - Writeback only. Required: busy = 0 and any_busy = 0.
- Enable hold: for 8 cycles keep wr_en=0 while wr_data toggles. Required: all 32 registers are unchanged; read back all 32 entries to confirm.
